// File: rtl/cpc_bus_pkg.sv
// Shared constants and helpers for the CPC bus-cycle sequencer.
package cpc_bus_pkg;

  localparam logic [1:0] MODE_NOWAIT  = 2'd0;
  localparam logic [1:0] MODE_LEGACY  = 2'd1;
  localparam logic [1:0] MODE_ALIGNED = 2'd2;

  typedef enum logic {
    IDLE,
    WAITING
  } wait_state_t;

  // Index width that never collapses to zero bits for a single channel.
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cpc_rr_arbiter.sv
// Round-robin pick of the lowest requesting channel at or after ptr, wrapping at N_CH.
module cpc_rr_arbiter #(
  parameter int N_CH = 3,
  parameter int CW   = 2
) (
  input  logic [N_CH-1:0] req,
  input  logic [CW-1:0]   ptr,
  input  logic            en,
  output logic [N_CH-1:0] gnt,
  output logic [CW-1:0]   idx,
  output logic [CW-1:0]   next_ptr
);

  logic found;

  // Pass 0 scans ptr..N_CH-1, pass 1 wraps to scan 0..ptr-1.
  always_comb begin
    gnt      = '0;
    idx      = '0;
    next_ptr = ptr;
    found    = 1'b0;
    for (int unsigned pass = 0; pass < 2; pass++) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (en && !found && req[i] &&
            ((pass == 0) == (i >= int'(unsigned'(ptr))))) begin
          found    = 1'b1;
          gnt[i]   = 1'b1;
          idx      = CW'(i);
          next_ptr = (i == N_CH - 1) ? '0 : CW'(i + 1);
        end
      end
    end
  end

endmodule

// File: rtl/cpc_bus_sequencer.sv
// CPU slot strobe, Z80 WAIT_n alignment and auxiliary-channel time multiplexing
// for the CPC motherboard; all state advances on ce_4p.
module cpc_bus_sequencer
  import cpc_bus_pkg::*;
#(
  parameter  int PERIOD    = 4,
  parameter  int DMA_PHASE = 1,
  parameter  int N_CH      = 3,
  parameter  int AW        = 23,
  localparam int PW        = $clog2(PERIOD),
  localparam int CW        = clog2_min1(N_CH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce_4p,
  input  logic [1:0]       mode,
  input  logic             mreq_n,
  input  logic             iorq_n,
  input  logic             rfsh_n,
  input  logic             m1_n,
  output logic             wait_n,
  output logic             slot,
  output logic [PW-1:0]    phase,
  input  logic [N_CH-1:0]  ch_req,
  input  logic [N_CH*AW-1:0] ch_addr,
  output logic [N_CH-1:0]  ch_gnt,
  output logic             dma_valid,
  output logic [CW-1:0]    dma_ch,
  output logic [AW-1:0]    dma_addr
);

  wait_state_t     state_q, state_d;
  logic            acc, acc_q, acc_rise;
  logic            at_end, at_dma;
  logic [CW-1:0]   rr_ptr;
  logic [N_CH-1:0] arb_gnt;
  logic [CW-1:0]   arb_idx, arb_next;

  assign at_end   = (phase == PW'(PERIOD - 1));
  assign at_dma   = (phase == PW'(DMA_PHASE));
  assign slot     = ce_4p & at_end;
  assign acc      = (~mreq_n & rfsh_n) | (~iorq_n & m1_n);
  assign acc_rise = acc & ~acc_q;
  assign wait_n   = (state_q == IDLE);

  // LEGACY's "slot wins" and ALIGNED's "no wait at the last phase" reduce to the
  // same priority: the last-phase tick always releases, otherwise a new access stalls.
  always_comb begin
    state_d = state_q;
    if (mode == MODE_NOWAIT)
      state_d = IDLE;
    else if (at_end)
      state_d = IDLE;
    else if (acc_rise)
      state_d = WAITING;
  end

  cpc_rr_arbiter #(
    .N_CH (N_CH),
    .CW   (CW)
  ) u_arb (
    .req      (ch_req),
    .ptr      (rr_ptr),
    .en       (at_dma),
    .gnt      (arb_gnt),
    .idx      (arb_idx),
    .next_ptr (arb_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase     <= '0;
      state_q   <= IDLE;
      acc_q     <= 1'b0;
      ch_gnt    <= '0;
      dma_valid <= 1'b0;
      dma_ch    <= '0;
      dma_addr  <= '0;
      rr_ptr    <= '0;
    end else if (ce_4p) begin
      phase     <= at_end ? '0 : phase + 1'b1;
      state_q   <= state_d;
      acc_q     <= acc;
      ch_gnt    <= arb_gnt;
      dma_valid <= |arb_gnt;
      if (|arb_gnt) begin
        dma_ch   <= arb_idx;
        dma_addr <= ch_addr[arb_idx*AW +: AW];
        rr_ptr   <= arb_next;
      end
    end
  end

endmodule
